pe_row_driver: RTL and testbench
================================

PE_ROW_DRIVER -- requirements
Module: pe_row_driver

Interface
REQ-001 Parameter N, default 4, number of PEs in the driven row (N >= 1).
REQ-002 Parameter LEN_W, default 8, width of the stream-length field.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to run one weight-load plus stream job.
REQ-006 abort  input  1  synchronous job cancel.
REQ-007 len_i  input  LEN_W  number of input samples in the job; sampled on an accepted start.
REQ-008 w_i  input  N*8  per-PE weights; PE k at bits [8k+7:8k]; sampled on an accepted start.
REQ-009 bias_i  input  N*8  per-PE partial-sum operand, same bit layout; sampled on an accepted start.
REQ-010 in_valid  input  1  input sample offered.
REQ-011 in_data  input  8  input sample.
REQ-012 in_ready  output  1  driver accepts the sample this cycle.
REQ-013 mode_o  output  2  mode driven to every PE in the row.
REQ-014 activate_o  output  1  activate driven to PE 0.
REQ-015 pe_in_o  output  8  data driven to PE 0.
REQ-016 pe_filter_o  output  N*8  per-PE filter/operand bus, same bit layout as w_i.
REQ-017 pe_out_last_i  input  8  pe_out of PE N-1.
REQ-018 res_valid  output  1  one result on res_data this cycle.
REQ-019 res_data  output  8  result sample.
REQ-020 busy  output  1  high in every state except IDLE.
REQ-021 done  output  1  one-cycle pulse at job end.

Function
REQ-022 Mode encoding SHALL be SINGLE=0, SA=1, SAVE=2, INIT=3.
REQ-023 FSM states SHALL be IDLE, LOAD, STREAM, DRAIN and DONE.
REQ-024 IDLE: mode_o=INIT, activate_o=0, pe_in_o=0, pe_filter_o=0, in_ready=0; start with len_i!=0 captures len_i, w_i and bias_i and moves to LOAD.
REQ-025 In IDLE, start with len_i==0 SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-026 LOAD lasts exactly 1 cycle: mode_o=SAVE, pe_filter_o=captured weights, activate_o=0; then the FSM moves to STREAM.
REQ-027 STREAM: mode_o=SA, pe_filter_o=captured bias, in_ready=1; on in_valid the sample is accepted with pe_in_o=in_data and activate_o=1, otherwise pe_in_o=0 and activate_o=0 (bubble).
REQ-028 mode_o, activate_o and pe_in_o SHALL be combinational from state and in_valid/in_data so the PEs register them in the acceptance cycle.
REQ-029 Accepted-sample counter SHALL reset to 0 at start; when the len-th sample is accepted, the FSM moves to DRAIN.
REQ-030 An N+1-stage activate delay line SHALL be shifted every cycle; res_valid is registered from stage N, and res_data is registered from pe_out_last_i in that cycle, giving an accept-to-res_valid latency of N+1 cycles.
REQ-031 DRAIN: mode_o=SA, activate_o=0, in_ready=0; it lasts N+1 cycles, then the FSM moves to DONE.
REQ-032 DONE lasts 1 cycle with done=1 and mode_o=INIT, then the FSM moves to IDLE.
REQ-033 Exactly len res_valid pulses SHALL occur per job, all before done, in acceptance order.
REQ-034 abort SHALL force IDLE on the next edge from any state, clear the delay line, counter and res_valid, and suppress done; abort takes priority over start.
REQ-035 Results SHALL use 8-bit wrap-around with no saturation.

Reset
REQ-036 During rst, state=IDLE, the counter and delay line are 0, captured registers are 0, and outputs hold the IDLE values of REQ-024 with res_valid=0, res_data=0, busy=0 and done=0.
REQ-037 Reset asserted mid-job SHALL discard the job with no done pulse.

Structure
REQ-038 Mode constants and the FSM state enumeration SHALL live in the shared PE package, pe_pkg.
REQ-039 The activate/result delay alignment SHALL be one sub-module, pe_act_delay, parameterised by depth.

Verification
REQ-040 N=4, w=1,2,3,4, bias=0, len=3, in 5,6,7 back-to-back: LOAD 1 cycle with mode_o=2; each res_valid comes 5 cycles after its accept, and res_data equals the model output; done once.
REQ-041 Same job with in_valid gaps of 2 cycles: activate_o=0 in bubble cycles, results keep order, count=3.
REQ-042 start with len_i=0: busy stays 0, and mode_o stays 3.
REQ-043 abort during STREAM after 2 accepts: next cycle IDLE, no done, no further res_valid.
REQ-044 rst pulse during DRAIN: all outputs take their reset values immediately; a new job then runs normally.
REQ-045 start pulsed while busy: ignored, and the current job completes with the original len.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared PE definitions: mode encoding driven to the PE row and the
// row-driver FSM state enumeration.
package pe_pkg;

    // Mode presented to every PE in a row.
    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_SA     = 2'd1,
        MODE_SAVE   = 2'd2,
        MODE_INIT   = 2'd3
    } pe_mode_e;

    // Row-driver job sequencing.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } pe_state_e;

endpackage

// File: rtl/pe_act_delay.sv
// Activate delay line that aligns each accepted sample with the result
// emerging from the last PE. The final stage is the result-valid register,
// so the accept-to-valid latency is DEPTH cycles.
module pe_act_delay #(
    parameter int DEPTH = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_act,
    input  logic [7:0] i_data,
    output logic       o_valid,
    output logic [7:0] o_data
);

    logic [DEPTH-1:0] r_stage;
    logic [DEPTH-1:0] w_next;
    logic [7:0]       r_data;

    assign w_next  = {r_stage[DEPTH-2:0], i_act};
    assign o_valid = r_stage[DEPTH-1];
    assign o_data  = r_data;

    // Shift the activate tokens every cycle; capture the last PE output
    // in the cycle its token reaches the valid stage.
    // NOTE: the delay line is a handful of flops, so it is reset like any
    // other control state; a cleared line guarantees no phantom results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= '0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_stage <= '0;
        end else begin
            r_stage <= w_next;
            if (w_next[DEPTH-1]) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/pe_row_driver.sv
// Row driver: loads per-PE weights, streams input samples into PE 0 in
// systolic mode, drains the row and collects results from the last PE.
module pe_row_driver
    import pe_pkg::*;
#(
    parameter int N     = 4,
    parameter int LEN_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [LEN_W-1:0]   len_i,
    input  logic [N*8-1:0]     w_i,
    input  logic [N*8-1:0]     bias_i,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic [1:0]         mode_o,
    output logic               activate_o,
    output logic [7:0]         pe_in_o,
    output logic [N*8-1:0]     pe_filter_o,
    input  logic [7:0]         pe_out_last_i,
    output logic               res_valid,
    output logic [7:0]         res_data,
    output logic               busy,
    output logic               done
);

    localparam int DW = $clog2(N + 1);

    pe_state_e        r_state;
    pe_state_e        w_next_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [DW-1:0]    r_drain;
    logic [N*8-1:0]   r_w;
    logic [N*8-1:0]   r_bias;
    logic             w_start_ok;
    logic             w_accept;
    logic             w_last_accept;

    assign w_start_ok    = start && (len_i != '0);
    assign w_accept      = (r_state == ST_STREAM) && in_valid;
    assign w_last_accept = w_accept && ((r_cnt + 1'b1) == r_len);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort overrides every transition, including start.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_start_ok) w_next_state = ST_LOAD;
            ST_LOAD:   w_next_state = ST_STREAM;
            ST_STREAM: if (w_last_accept) w_next_state = ST_DRAIN;
            ST_DRAIN:  if (r_drain == DW'(N)) w_next_state = ST_DONE;
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
        if (abort) begin
            w_next_state = ST_IDLE;
        end
    end

    // Job operands, accepted-sample counter and drain-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len   <= '0;
            r_cnt   <= '0;
            r_drain <= '0;
            r_w     <= '0;
            r_bias  <= '0;
        end else if (abort) begin
            r_cnt   <= '0;
            r_drain <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_start_ok) begin
                r_len  <= len_i;
                r_w    <= w_i;
                r_bias <= bias_i;
                r_cnt  <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == ST_DRAIN) begin
                r_drain <= r_drain + 1'b1;
            end else begin
                r_drain <= '0;
            end
        end
    end

    // Row-facing outputs, combinational so PEs register them in the
    // acceptance cycle.
    // NOTE: every output gets its IDLE value first, so no path through the
    // case leaves one unassigned and no latch is inferred.
    always_comb begin
        mode_o      = MODE_INIT;
        activate_o  = 1'b0;
        pe_in_o     = '0;
        pe_filter_o = '0;
        in_ready    = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_LOAD: begin
                mode_o      = MODE_SAVE;
                pe_filter_o = r_w;
            end
            ST_STREAM: begin
                mode_o      = MODE_SA;
                pe_filter_o = r_bias;
                in_ready    = 1'b1;
                if (in_valid) begin
                    activate_o = 1'b1;
                    pe_in_o    = in_data;
                end
            end
            ST_DRAIN: begin
                mode_o      = MODE_SA;
                pe_filter_o = r_bias;
            end
            ST_DONE: begin
                done = !abort;
            end
            default: ;
        endcase
    end

    assign busy = (r_state != ST_IDLE);

    pe_act_delay #(
        .DEPTH (N + 1)
    ) u_act_delay (
        .clk     (clk),
        .rst     (rst),
        .i_clear (abort),
        .i_act   (activate_o),
        .i_data  (pe_out_last_i),
        .o_valid (res_valid),
        .o_data  (res_data)
    );

endmodule

// File: tb/tb_pe_row_driver.sv
// Self-checking bench for pe_row_driver. A stand-in PE row produces, for
// each accepted sample x, sum_k(w_k*x + b_k) mod 256 on pe_out_last_i N
// cycles after acceptance; a scoreboard queue holds expected results.
module tb_pe_row_driver;

    localparam int N     = 4;
    localparam int LEN_W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] len_i;
    logic [N*8-1:0]   w_i;
    logic [N*8-1:0]   bias_i;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic [1:0]       mode_o;
    logic             activate_o;
    logic [7:0]       pe_in_o;
    logic [N*8-1:0]   pe_filter_o;
    logic [7:0]       pe_out_last_i;
    logic             res_valid;
    logic [7:0]       res_data;
    logic             busy;
    logic             done;

    pe_row_driver #(.N(N), .LEN_W(LEN_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .len_i         (len_i),
        .w_i           (w_i),
        .bias_i        (bias_i),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .mode_o        (mode_o),
        .activate_o    (activate_o),
        .pe_in_o       (pe_in_o),
        .pe_filter_o   (pe_filter_o),
        .pe_out_last_i (pe_out_last_i),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_err  = 0;
    int n_res  = 0;
    int n_done = 0;
    int cyc    = 0;
    int last_acc = 0;
    int done_cyc = 0;

    logic [N*8-1:0] cur_w = '0;
    logic [N*8-1:0] cur_b = '0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    typedef struct {
        logic [7:0]     len;
        logic [N*8-1:0] w;
        logic [N*8-1:0] b;
        int             gap;
        bit             poke;
        int             exp_res;
    } job_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [7:0] row_fn(input logic [7:0] x);
        logic [7:0] acc = '0;
        for (int k = 0; k < N; k++) begin
            acc = acc + cur_w[8*k +: 8] * x + cur_b[8*k +: 8];
        end
        return acc;
    endfunction

    // Stand-in PE row: junk when idle, the job's result N cycles after accept.
    logic [7:0] r_sr [N];
    always @(posedge clk) begin
        r_sr[0] <= activate_o ? row_fn(in_data) : 8'($urandom);
        for (int i = 1; i < N; i++) r_sr[i] <= r_sr[i-1];
    end
    assign pe_out_last_i = r_sr[N-1];

    // Monitor: scoreboard, latency and per-cycle handshake checks.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            cyc++;
            if (res_valid) begin
                n_res++;
                check("res_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("res_data", 32'(res_data), 32'(mon_e.data));
                    check("res_latency", cyc - mon_e.cyc, N + 1);
                end
            end
            if (in_ready) check("act_follows_valid", 32'(activate_o), 32'(in_valid));
            if (activate_o) begin
                check("pe_in", 32'(pe_in_o), 32'(in_data));
                exp_q.push_back('{row_fn(in_data), cyc});
                last_acc = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                check("done_after_results", exp_q.size(), 0);
            end
            if (abort) exp_q.delete();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] len, input logic [N*8-1:0] w, input logic [N*8-1:0] b);
        start  = 1'b1;
        len_i  = len;
        w_i    = w;
        bias_i = b;
        cur_w  = w;
        cur_b  = b;
        #1;
        check("idle_mode", 32'(mode_o), 3);
        check("idle_busy", 32'(busy), 0);
        tick();
        start = 1'b0;
    endtask

    task automatic run_job(input job_t j);
        int d0, r0, k;
        d0 = n_done;
        r0 = n_res;
        do_start(j.len, j.w, j.b);
        if (j.poke) begin
            start = 1'b1; len_i = 8'd9; w_i = ~j.w;
        end
        #1;
        check("load_mode", 32'(mode_o), 2);
        check("load_filter", pe_filter_o, j.w);
        check("load_act", 32'(activate_o), 0);
        check("load_busy", 32'(busy), 1);
        tick();
        check("stream_mode", 32'(mode_o), 1);
        check("stream_filter", pe_filter_o, j.b);
        for (int i = 0; i < int'(j.len); i++) begin
            for (int g = 0; g < j.gap; g++) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        start    = 1'b0;
        k = 0;
        while (n_done == d0 && k < 200) begin
            tick();
            k++;
        end
        check("done_timeout", 32'(k < 200), 1);
        check("drain_len", done_cyc - last_acc, N + 2);
        check("back_idle_busy", 32'(busy), 0);
        check("back_idle_mode", 32'(mode_o), 3);
        repeat (2) tick();
        check("res_count", n_res - r0, j.exp_res);
        check("done_count", n_done - d0, 1);
    endtask

    job_t jobs[5];
    job_t rj;
    int   d0, r0;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; len_i = '0; w_i = '0;
        bias_i = '0; in_valid = 1'b0; in_data = '0;

        jobs[0] = '{8'd3,  32'h0403_0201, 32'h0000_0000, 0, 1'b0, 3};
        jobs[1] = '{8'd3,  32'h0403_0201, 32'h0000_0000, 2, 1'b0, 3};
        jobs[2] = '{8'd1,  32'h1122_3344, 32'h1020_3040, 0, 1'b0, 1};
        jobs[3] = '{8'd10, 32'hFFFE_FD80, 32'h7F80_7F80, 1, 1'b0, 10};
        jobs[4] = '{8'd4,  32'h0101_0101, 32'h0506_0708, 0, 1'b1, 4};

        repeat (2) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_mode", 32'(mode_o), 3);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_data", 32'(res_data), 0);
        check("rst_done", 32'(done), 0);
        check("rst_filter", pe_filter_o, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_job(jobs[i]);

        // Zero-length start is ignored.
        start = 1'b1; len_i = 8'd0; w_i = 32'hDEAD_BEEF;
        tick();
        start = 1'b0;
        check("len0_busy", 32'(busy), 0);
        check("len0_mode", 32'(mode_o), 3);
        tick();
        check("len0_busy_later", 32'(busy), 0);

        // Abort in STREAM after two accepts.
        d0 = n_done;
        do_start(8'd6, 32'h0201_0403, 32'h0101_0101);
        tick();
        in_valid = 1'b1; in_data = 8'($urandom);
        tick();
        in_data = 8'($urandom);
        tick();
        in_valid = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle_busy", 32'(busy), 0);
        check("abort_idle_mode", 32'(mode_o), 3);
        check("abort_in_ready", 32'(in_ready), 0);
        r0 = n_res;
        repeat (12) tick();
        check("abort_no_res", n_res - r0, 0);
        check("abort_no_done", n_done - d0, 0);

        // Reset pulse during DRAIN, then a normal job.
        d0 = n_done;
        do_start(8'd2, 32'h0102_0304, 32'h0A0B_0C0D);
        tick();
        in_valid = 1'b1; in_data = 8'($urandom);
        tick();
        in_data = 8'($urandom);
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_mode", 32'(mode_o), 3);
        check("rstmid_res_valid", 32'(res_valid), 0);
        check("rstmid_res_data", 32'(res_data), 0);
        check("rstmid_done", 32'(done), 0);
        check("rstmid_filter", pe_filter_o, 0);
        tick();
        rst = 1'b0;
        check("rstmid_no_done", n_done - d0, 0);
        tick();
        run_job(jobs[0]);

        // Randomised jobs against the scoreboard.
        for (int i = 0; i < 6; i++) begin
            rj.len     = 8'($urandom_range(1, 12));
            rj.w       = $urandom;
            rj.b       = $urandom;
            rj.gap     = int'($urandom_range(0, 2));
            rj.poke    = 1'b0;
            rj.exp_res = int'(rj.len);
            run_job(rj);
        end

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
